interleaver: RTL and testbench
==============================

INTERLEAVER -- requirements
Module: interleaver

Interface
REQ-001 Parameters: none; K values and QPP coefficients SHALL be fixed constants.
REQ-002 clk  input  1  single clock; all logic SHALL operate on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 vld_crc  input  1  upstream byte valid; a byte SHALL be accepted on each edge where vld_crc=1 and rdy_crc=1.
REQ-005 rdy_out  input  1  downstream ready; an output byte SHALL be consumed on each edge where vld_out=1 and rdy_out=1.
REQ-006 cbs  input  1  code block size select: 0 -> K=1056 (f1=17, f2=66); 1 -> K=6144 (f1=263, f2=480).
REQ-007 data_in  input  8  input byte; data_in[7] is the earliest bit in stream order.
REQ-008 rdy_crc  output  1  block SHALL accept input bytes.
REQ-009 vld_out  output  1  data_out holds a valid interleaved byte.
REQ-010 last_byte  output  1  high together with vld_out on the final byte of a block.
REQ-011 data_out  output  8  output byte; data_out[7] is the earliest bit in stream order.

Function
REQ-012 Input stream bit c(k), k=0..K-1: byte n carries c(8n+7-j) on data_in[j].
REQ-013 Output bit c'(i) SHALL equal c(pi(i)), pi(i) = (f1*i + f2*i*i) mod K, i=0..K-1; data_out of byte m carries c'(8m+7-j) on bit j.
REQ-014 pi SHALL be generated recursively with modular adds only (no multipliers): pi(0)=0, g(0)=(f1+f2) mod K, pi(i+1)=(pi(i)+g(i)) mod K, g(i+1)=(g(i)+2*f2) mod K; each mod is a single conditional subtract of K.
REQ-015 Storage: two bit-addressable buffers of 6144 bits each (input, output); for K=1056 only bits 0..1055 are used.
REQ-016 States: IDLE, LOAD, PERMUTE, SEND.
REQ-017 IDLE: rdy_crc=1, vld_out=0; cbs is latched on the edge the first byte is accepted (transition to LOAD with byte count 1); cbs changes afterwards are ignored until the next IDLE.
REQ-018 LOAD: rdy_crc=1; each accepted byte is written at bits 8n..8n+7; the edge accepting byte K/8-1 (131 or 767) SHALL move to PERMUTE; vld_crc=0 cycles stall without loss.
REQ-019 PERMUTE: rdy_crc=0, vld_out=0; one bit per cycle, out[i] <= in[pi(i)], for exactly K cycles, then SEND.
REQ-020 SEND: vld_out=1, data_out = output byte m (m from 0); m increments only on vld_out&rdy_out; rdy_out=0 SHALL hold data_out, vld_out stable.
REQ-021 last_byte=1 iff state=SEND and m=K/8-1; consuming that byte SHALL return to IDLE (rdy_crc=1 the next cycle).
REQ-022 Latency: first output byte valid K cycles after the edge accepting the last input byte (+1 state-register cycle); full-throughput block period = K/8 + K + K/8 cycles.
REQ-023 rdy_crc and vld_out SHALL never be 1 in the same cycle; no input is accepted outside IDLE/LOAD.
REQ-024 All outputs SHALL be registered or decoded from registered state only.

Reset
REQ-025 reset=1 on an edge SHALL force IDLE, byte/bit counters and recursion registers to 0, cbs latch to 0, and drive rdy_crc=0 while reset is high, vld_out=0, last_byte=0, data_out=8'h00.
REQ-026 Reset asserted mid-LOAD, PERMUTE or SEND SHALL abandon the block; the first cycle after release SHALL be IDLE with rdy_crc=1; buffer contents need not be cleared.

Verification
REQ-027 cbs=0, 132 bytes 8'h00, rdy_out=1 -> 132 bytes 8'h00, last_byte only on byte 131, rdy_crc returns high after it.
REQ-028 cbs=0, only c(83)=1 (byte 10 = 8'h10) -> output byte 0 = 8'h40 (c'(1)=1, pi(1)=83), all others 8'h00; c(298) alone -> byte 0 = 8'h20 (pi(2)=298).
REQ-029 cbs=0 random 1056-bit block -> output matches software QPP model bit-exact; vld_out first high 1056(+1) cycles after last input byte.
REQ-030 cbs=1, 768 bytes with only c(743)=1 (pi(1)=263+480) -> output byte 0 = 8'h40, last_byte on byte 767.
REQ-031 rdy_out toggled pseudo-randomly in SEND, vld_crc gapped in LOAD -> identical output to REQ-029; data_out stable while rdy_out=0.
REQ-032 reset pulsed at input byte 50 and again in PERMUTE -> all outputs return to reset values; next full block interleaves correctly.

Source files
------------

// File: rtl/interleaver.sv
// rtl/interleaver.sv - QPP turbo-code interleaver for K=1056 / K=6144 byte streams.
// Bytes are loaded into a bit buffer, permuted one bit per cycle, then streamed out.
module interleaver (
  input  logic       clk,
  input  logic       reset,
  input  logic       vld_crc,
  input  logic       rdy_out,
  input  logic       cbs,
  input  logic [7:0] data_in,
  output logic       rdy_crc,
  output logic       vld_out,
  output logic       last_byte,
  output logic [7:0] data_out
);

  typedef enum logic [1:0] {IDLE, LOAD, PERMUTE, SEND} state_t;

  state_t      state, state_nxt;
  logic        cbs_q;
  logic        rst_hold;
  logic [9:0]  byte_cnt;
  logic [12:0] bit_cnt;
  logic [12:0] pi, g;

  logic in_buf  [0:6143];
  logic out_buf [0:6143];

  logic [12:0] k;
  logic [9:0]  last_idx;
  logic [12:0] g0;
  logic [12:0] two_f2;
  logic [13:0] pi_sum, g_sum;
  logic [12:0] pi_nxt, g_nxt;
  logic        accept, take;
  logic [12:0] byte_base;

  always_comb begin
    k        = cbs_q ? 13'd6144 : 13'd1056;
    last_idx = cbs_q ? 10'd767  : 10'd131;
    g0       = cbs_q ? 13'd743  : 13'd83;
    two_f2   = cbs_q ? 13'd960  : 13'd132;
  end

  // Both operands are already reduced mod K, so one conditional subtract suffices.
  always_comb begin
    pi_sum = {1'b0, pi} + {1'b0, g};
    g_sum  = {1'b0, g} + {1'b0, two_f2};
    pi_nxt = (pi_sum >= {1'b0, k}) ? 13'(pi_sum - {1'b0, k}) : pi_sum[12:0];
    g_nxt  = (g_sum  >= {1'b0, k}) ? 13'(g_sum  - {1'b0, k}) : g_sum[12:0];
  end

  assign accept    = vld_crc & rdy_crc;
  assign take      = vld_out & rdy_out;
  assign byte_base = {byte_cnt, 3'b000};

  always_comb begin
    state_nxt = state;
    rdy_crc   = 1'b0;
    vld_out   = 1'b0;
    case (state)
      IDLE: begin
        rdy_crc = ~rst_hold;
        if (accept) state_nxt = LOAD;
      end
      LOAD: begin
        rdy_crc = ~rst_hold;
        if (accept && byte_cnt == last_idx) state_nxt = PERMUTE;
      end
      PERMUTE: begin
        if (bit_cnt == k - 13'd1) state_nxt = SEND;
      end
      SEND: begin
        vld_out = 1'b1;
        if (take && byte_cnt == last_idx) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rst_hold keeps rdy_crc low for as long as reset is sampled high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rst_hold <= 1'b1;
      cbs_q    <= 1'b0;
      byte_cnt <= 10'd0;
      bit_cnt  <= 13'd0;
      pi       <= 13'd0;
      g        <= 13'd0;
    end else begin
      state    <= state_nxt;
      rst_hold <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cbs_q    <= cbs;
            byte_cnt <= 10'd1;
          end
        end
        LOAD: begin
          if (accept) begin
            if (byte_cnt == last_idx) begin
              byte_cnt <= 10'd0;
              bit_cnt  <= 13'd0;
              pi       <= 13'd0;
              g        <= g0;
            end else begin
              byte_cnt <= byte_cnt + 10'd1;
            end
          end
        end
        PERMUTE: begin
          pi      <= pi_nxt;
          g       <= g_nxt;
          bit_cnt <= bit_cnt + 13'd1;
        end
        SEND: begin
          if (take) byte_cnt <= (byte_cnt == last_idx) ? 10'd0 : byte_cnt + 10'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < 8; j++) in_buf[byte_base + 13'(7 - j)] <= data_in[j];
    end
    if (state == PERMUTE) out_buf[bit_cnt] <= in_buf[pi];
  end

  always_comb begin
    data_out = 8'h00;
    if (state == SEND) begin
      for (int j = 0; j < 8; j++) data_out[j] = out_buf[byte_base + 13'(7 - j)];
    end
  end

  assign last_byte = (state == SEND) && (byte_cnt == last_idx);

endmodule

// File: tb/tb_interleaver.sv
// tb/tb_interleaver.sv - directed table-driven bench for the QPP interleaver.
// Expected bytes come from a direct (multiplying) QPP model plus hand-computed values.
module tb_interleaver;

  logic       clk = 1'b0;
  logic       reset, vld_crc, rdy_out, cbs;
  logic [7:0] data_in;
  logic       rdy_crc, vld_out, last_byte;
  logic [7:0] data_out;

  interleaver dut (
    .clk(clk), .reset(reset), .vld_crc(vld_crc), .rdy_out(rdy_out), .cbs(cbs),
    .data_in(data_in), .rdy_crc(rdy_crc), .vld_out(vld_out), .last_byte(last_byte),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  bit         in_bits   [0:6143];
  logic [7:0] got_bytes [0:767];

  typedef struct {
    bit         sel;
    int         set_bit;
    int         seed;
    bit         gaps;
    bit         bp;
    int         chk_byte;
    logic [7:0] chk_val;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int qpp(input int kk, input int i);
    longint f1, f2;
    f1 = (kk == 6144) ? 263 : 17;
    f2 = (kk == 6144) ? 480 : 66;
    return int'((f1 * i + f2 * i * i) % kk);
  endfunction

  task automatic fill(input int kk, input int seed, input int set_bit);
    int s;
    s = seed;
    for (int b = 0; b < 6144; b++) in_bits[b] = 1'b0;
    if (seed != 0) begin
      for (int b = 0; b < kk; b++) begin
        s = s * 1103515245 + 12345;
        in_bits[b] = s[16];
      end
    end
    if (set_bit >= 0) in_bits[set_bit] = 1'b1;
  endtask

  // cbs is flipped after the first byte to confirm the size is latched once.
  task automatic send_block(input bit sel, input int nbytes, input bit gaps, output int last_cyc);
    int t;
    last_cyc = 0;
    for (int n = 0; n < nbytes; n++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          vld_crc = 1'b0;
        end
      end
      @(negedge clk);
      vld_crc = 1'b1;
      cbs = (n == 0) ? sel : ~sel;
      for (int j = 0; j < 8; j++) data_in[j] = in_bits[8 * n + 7 - j];
      t = 0;
      while (!rdy_crc && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t == 100) begin
        check("input_accept_timeout", 32'd0, 32'd1);
        vld_crc = 1'b0;
        return;
      end
      @(posedge clk);
      #1 last_cyc = cyc;
    end
    @(negedge clk);
    vld_crc = 1'b0;
  endtask

  task automatic recv_block(input bit sel, input bit bp, input int t_last_in);
    int kk, nb, m, t, lat, bad_data, bad_last, bad_stable, bad_excl;
    bit first_seen, holding;
    logic [7:0] held;
    logic [7:0] exp_b [0:767];
    kk = sel ? 6144 : 1056;
    nb = kk / 8;
    for (int mm = 0; mm < nb; mm++)
      for (int j = 0; j < 8; j++) exp_b[mm][j] = in_bits[qpp(kk, 8 * mm + 7 - j)];
    m = 0; t = 0; lat = -1; first_seen = 0; holding = 0; held = 8'h00;
    bad_data = 0; bad_last = 0; bad_stable = 0; bad_excl = 0;
    while (m < nb && t < 20000) begin
      @(negedge clk);
      t++;
      if (vld_out && rdy_crc) bad_excl++;
      rdy_out = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (vld_out) begin
        if (!first_seen) begin
          first_seen = 1;
          lat = cyc - t_last_in;
        end
        if (holding && data_out !== held) bad_stable++;
        if (last_byte !== (m == nb - 1)) bad_last++;
        if (rdy_out) begin
          got_bytes[m] = data_out;
          if (data_out !== exp_b[m]) bad_data++;
          m++;
          holding = 0;
        end else begin
          holding = 1;
          held = data_out;
        end
      end
    end
    check("bytes_received", m, nb);
    check("first_output_latency", lat, kk);
    check("output_vs_qpp_model_mismatches", bad_data, 0);
    check("last_byte_placement_errors", bad_last, 0);
    check("rdy_crc_and_vld_out_overlap", bad_excl, 0);
    if (bp) check("data_out_unstable_while_stalled", bad_stable, 0);
    @(negedge clk);
    rdy_out = 1'b0;
    check("rdy_crc_after_last_byte", rdy_crc, 1);
    check("vld_out_after_last_byte", vld_out, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy_crc"}, rdy_crc, 0);
    check({tag, "_vld_out"}, vld_out, 0);
    check({tag, "_last_byte"}, last_byte, 0);
    check({tag, "_data_out"}, data_out, 8'h00);
  endtask

  initial begin
    vec_t vecs [7];
    int   tl;
    int   kk;

    // sel, set_bit, seed, gaps, bp, chk_byte, chk_val
    vecs[0] = '{1'b0,  -1,    0, 1'b0, 1'b0, 131, 8'h00};
    vecs[1] = '{1'b0,  83,    0, 1'b0, 1'b0,   0, 8'h40};
    vecs[2] = '{1'b0, 298,    0, 1'b0, 1'b0,   0, 8'h20};
    vecs[3] = '{1'b0,   0,    0, 1'b0, 1'b0,   0, 8'h80};
    vecs[4] = '{1'b1, 743,    0, 1'b0, 1'b0,   0, 8'h40};
    vecs[5] = '{1'b0,  -1, 4711, 1'b0, 1'b0,  -1, 8'h00};
    vecs[6] = '{1'b0,  -1, 4711, 1'b1, 1'b1,  -1, 8'h00};

    reset = 1'b1; vld_crc = 1'b0; rdy_out = 1'b0; cbs = 1'b0; data_in = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    @(negedge clk);
    check("por_release_rdy_crc", rdy_crc, 1);

    for (int v = 0; v < 7; v++) begin
      kk = vecs[v].sel ? 6144 : 1056;
      fill(kk, vecs[v].seed, vecs[v].set_bit);
      send_block(vecs[v].sel, kk / 8, vecs[v].gaps, tl);
      recv_block(vecs[v].sel, vecs[v].bp, tl);
      if (vecs[v].chk_byte >= 0)
        check($sformatf("vec%0d_byte%0d", v, vecs[v].chk_byte),
              got_bytes[vecs[v].chk_byte], vecs[v].chk_val);
    end

    // Reset partway through LOAD.
    fill(1056, 99, -1);
    send_block(1'b0, 50, 1'b0, tl);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("load_rst");
    reset = 1'b0;
    @(negedge clk);
    check("load_rst_release_rdy_crc", rdy_crc, 1);

    // Reset during PERMUTE; the abandoned block must never appear.
    send_block(1'b0, 132, 1'b0, tl);
    repeat (100) @(negedge clk);
    check("in_permute_rdy_crc", rdy_crc, 0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("perm_rst");
    reset = 1'b0;
    @(negedge clk);
    check("perm_rst_release_rdy_crc", rdy_crc, 1);
    repeat (1200) @(negedge clk);
    check("abandoned_block_vld_out", vld_out, 0);

    fill(1056, 2024, -1);
    send_block(1'b0, 132, 1'b1, tl);
    recv_block(1'b0, 1'b1, tl);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
